// File: rtl/pipeline_pkg.sv
// Shared front-end pipeline definitions: default PC width, reset PC and the
// fetch redirect controller state encoding.
package pipeline_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner and redirect sequencer (BOOT/RUN/PEND); redirects that hit an
// outstanding fetch are parked in PEND. Statistics counters under FETCH_REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
  parameter int unsigned     XLEN     = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = pipeline_pkg::RESET_PC,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            jump,
  input  logic [XLEN-1:0] next,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            imem_req,
  output logic            fetch_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            redirect_pending,
  output logic [31:0]     redirect_count,
  output logic [31:0]     pend_count
);

  import pipeline_pkg::*;

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] pend_target, pend_target_n;
  logic            redir;
  logic            pend_enter;

  assign redir      = ex_valid & jump & (state != BOOT);
  assign pend_enter = (state == RUN) & redir & ~imem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_target <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_target <= pend_target_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    pend_target_n = pend_target;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (redir) begin
          if (imem_ready) begin
            pc_n = next;
          end else begin
            pend_target_n = next;
            state_n       = PEND;
          end
        end else if (!stall && imem_ready) begin
          pc_n = pc + XLEN'(PC_STEP);
        end
      end
      PEND: begin
        // A redirect arriving in the same cycle supersedes the parked target.
        if (redir) pend_target_n = next;
        if (imem_ready) begin
          pc_n    = redir ? next : pend_target;
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  assign imem_req         = (state != BOOT);
  assign redirect_pending = (state == PEND);
  assign fetch_valid      = imem_ready & (state == RUN) & ~redir & ~stall;
  assign flush_if_id      = redir;
  assign flush_id_ex      = redir;

`ifdef FETCH_REDIRECT_STATS_EN
  sat_counter #(.WIDTH(32)) u_redirect_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (redir),
    .count (redirect_count)
  );

  sat_counter #(.WIDTH(32)) u_pend_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (pend_enter),
    .count (pend_count)
  );
`else
  assign redirect_count = '0;
  assign pend_count     = '0;
  logic unused_stats;
  assign unused_stats = pend_enter;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Table-driven scoreboard bench for fetch_redirect_ctrl, plus a reset-mid-PEND sequence.
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        jump;
  logic [31:0] next;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
  logic [31:0] redirect_count;
  logic [31:0] pend_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fetch_redirect_ctrl #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .PC_STEP  (1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .jump             (jump),
    .next             (next),
    .stall            (stall),
    .imem_ready       (imem_ready),
    .pc               (pc),
    .imem_req         (imem_req),
    .fetch_valid      (fetch_valid),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_pending (redirect_pending),
    .redirect_count   (redirect_count),
    .pend_count       (pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic        jmp;
    logic [31:0] nxt;
    logic        stl;
    logic        rdy;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_fv;
    logic        e_fl;
    logic        e_pd;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        req;
    logic        fv;
    logic        fl;
    logic        pd;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=0x%08h required=0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    chk("pc",          e.idx, pc,                 e.pc);
    chk("imem_req",    e.idx, 32'(imem_req),      32'(e.req));
    chk("fetch_valid", e.idx, 32'(fetch_valid),   32'(e.fv));
    chk("flush_if_id", e.idx, 32'(flush_if_id),   32'(e.fl));
    chk("flush_id_ex", e.idx, 32'(flush_id_ex),   32'(e.fl));
    chk("pending",     e.idx, 32'(redirect_pending), 32'(e.pd));
  endtask

  // Drive one cycle at the falling edge, then sample just before the next rise.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    ex_valid   = v.ev;
    jump       = v.jmp;
    next       = v.nxt;
    stall      = v.stl;
    imem_ready = v.rdy;
    e.idx = idx; e.pc = v.e_pc; e.req = v.e_req; e.fv = v.e_fv; e.fl = v.e_fl; e.pd = v.e_pd;
    sb.push_back(e);
    #2;
    compare_front();
    @(negedge clk);
  endtask

  vec_t tbl[$];
  logic [31:0] exp_redir_cnt;
  logic [31:0] exp_pend_cnt;

  initial begin
    //            ev   jmp  next          stl  rdy   pc            req  fv   fl   pd
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h0,        1'b0,1'b0,1'b0,1'b0}); // BOOT
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h0,        1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h1,        1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h2,        1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h3,        1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h4,        1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h40,      1'b0,1'b1, 32'h5,        1'b1,1'b0,1'b1,1'b0}); // redir, ready
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h40,       1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h80,      1'b0,1'b0, 32'h41,       1'b1,1'b0,1'b1,1'b0}); // enter PEND
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0, 32'h41,       1'b1,1'b0,1'b0,1'b1});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0, 32'h41,       1'b1,1'b0,1'b0,1'b1});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h41,       1'b1,1'b0,1'b0,1'b1}); // wrong-path return
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h80,       1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h90,      1'b0,1'b0, 32'h81,       1'b1,1'b0,1'b1,1'b0}); // enter PEND
    tbl.push_back('{1'b1,1'b1,32'hC0,      1'b0,1'b1, 32'h81,       1'b1,1'b0,1'b1,1'b1}); // newer target + ready
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'hC0,       1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h100,     1'b0,1'b0, 32'hC1,       1'b1,1'b0,1'b1,1'b0}); // enter PEND
    tbl.push_back('{1'b1,1'b1,32'h200,     1'b0,1'b0, 32'hC1,       1'b1,1'b0,1'b1,1'b1}); // replace parked target
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b1, 32'hC1,       1'b1,1'b0,1'b0,1'b1}); // stall ignored in PEND
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h200,      1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'h10,      1'b1,1'b1, 32'h201,      1'b1,1'b0,1'b1,1'b0}); // redir beats stall
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b1, 32'h10,       1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b1,1'b1, 32'h10,       1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b0, 32'h10,       1'b1,1'b0,1'b0,1'b0});
    tbl.push_back('{1'b0,1'b1,32'h55,      1'b0,1'b1, 32'h10,       1'b1,1'b1,1'b0,1'b0}); // jump w/o ex_valid
    tbl.push_back('{1'b1,1'b0,32'h55,      1'b0,1'b1, 32'h11,       1'b1,1'b1,1'b0,1'b0});
    tbl.push_back('{1'b1,1'b1,32'hFFFFFFFF,1'b0,1'b1, 32'h12,       1'b1,1'b0,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'hFFFFFFFF, 1'b1,1'b1,1'b0,1'b0}); // wraps
    tbl.push_back('{1'b0,1'b0,32'h0,       1'b0,1'b1, 32'h0,        1'b1,1'b1,1'b0,1'b0});

`ifdef FETCH_REDIRECT_STATS_EN
    exp_redir_cnt = 32'd8;
    exp_pend_cnt  = 32'd3;
`else
    exp_redir_cnt = 32'd0;
    exp_pend_cnt  = 32'd0;
`endif

    reset = 1'b1; ex_valid = 1'b0; jump = 1'b0; next = '0; stall = 1'b0; imem_ready = 1'b0;
    #2;
    chk("reset_pc",      -1, pc, 32'h0);
    chk("reset_req",     -1, 32'(imem_req), 32'h0);
    chk("reset_pending", -1, 32'(redirect_pending), 32'h0);
    chk("reset_rcnt",    -1, redirect_count, 32'h0);
    chk("reset_pcnt",    -1, pend_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply(i, tbl[i]);

    chk("redirect_count", -1, redirect_count, exp_redir_cnt);
    chk("pend_count",     -1, pend_count,     exp_pend_cnt);

    // Reset while a redirect is parked: target discarded, back to BOOT at once.
    apply(100, '{1'b1,1'b1,32'h300, 1'b0,1'b0, 32'h1, 1'b1,1'b0,1'b1,1'b0});
    ex_valid = 1'b0; jump = 1'b0; imem_ready = 1'b0;
    #2;
    chk("pend_before_reset", 101, 32'(redirect_pending), 32'h1);
    reset = 1'b1;
    #1;
    chk("midpend_pc",      102, pc, 32'h0);
    chk("midpend_pending", 102, 32'(redirect_pending), 32'h0);
    chk("midpend_req",     102, 32'(imem_req), 32'h0);
    chk("midpend_rcnt",    102, redirect_count, 32'h0);
    chk("midpend_pcnt",    102, pend_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // jump during BOOT is ignored: no flush, pc not redirected
    apply(103, '{1'b1,1'b1,32'h77, 1'b0,1'b1, 32'h0, 1'b0,1'b0,1'b0,1'b0});
    apply(104, '{1'b0,1'b0,32'h0,  1'b0,1'b1, 32'h0, 1'b1,1'b1,1'b0,1'b0});
    apply(105, '{1'b0,1'b0,32'h0,  1'b0,1'b1, 32'h1, 1'b1,1'b1,1'b0,1'b0});

    chk("scoreboard_drained", -1, 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Front-end controller that owns the fetch PC and sequences control-flow redirects from the execute-stage branch/jump resolution logic. It advances the word-indexed PC, handshakes with instruction memory, and applies a resolved jump by flushing wrong-path instructions in IF/ID and ID/EX. A redirect that arrives while a fetch is still outstanding is parked until memory responds. Sits between the hazard unit, instruction memory, and the IF/ID register.

## Interface
Parameters:
- XLEN, 32, PC and target width.
- RESET_PC, 32'h0, PC value loaded at reset.
- PC_STEP, 1, sequential PC increment; PC is word-indexed, matching branch target arithmetic.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction (not a bubble).
- jump  in  1  EX resolved a taken branch, jal or jalr.
- next  in  XLEN  redirect target from EX.
- stall  in  1  hazard unit holds PC and IF/ID.
- imem_ready  in  1  instruction memory returns the word for `pc` this cycle.
- pc  out  XLEN  current fetch address.
- imem_req  out  1  fetch request.
- fetch_valid  out  1  IF/ID may capture the returned instruction.
- flush_if_id  out  1  squash IF/ID at next edge.
- flush_id_ex  out  1  squash ID/EX at next edge.
- redirect_pending  out  1  state is PEND.
- redirect_count  out  32  taken redirects (stats).
- pend_count  out  32  redirects that entered PEND (stats).

## Operation
- Let `redir = ex_valid & jump & (state != BOOT)`.
- States: BOOT, RUN, PEND.
- BOOT: entered on reset. imem_req=0, fetch_valid=0. Unconditionally moves to RUN on the next edge. jump is ignored.
- RUN:
  - If redir & imem_ready: pc<=next; stay in RUN.
  - If redir & ~imem_ready: pend_target<=next; go to PEND; pc holds.
  - Else if stall: pc holds.
  - Else if imem_ready: pc<=pc+PC_STEP.
  - Else: pc holds.
- PEND:
  - If redir: pend_target<=next. The newer target wins, and the effective target is next, not pend_target.
  - If imem_ready: pc<=effective target and go to RUN. The returned word is wrong-path and is discarded.
  - stall is ignored in PEND.
- fetch_valid = imem_ready & (state==RUN) & ~redir & ~stall.
- flush_if_id = flush_id_ex = redir (combinational). redir has priority over stall.
- imem_req = (state != BOOT).
- redirect_pending = (state==PEND).
- Arithmetic: pc+PC_STEP is taken modulo 2^XLEN; the all-ones PC wraps to 0 with no flag. next is used unmodified.

## Timing
- Reset values: pc=RESET_PC, state=BOOT, pend_target=0, counters=0. All outputs low except pc.
- The first fetch request is issued one cycle after reset deasserts.
- Redirect latency:
  - imem_ready high: redir in cycle T gives pc=next in T+1, with a valid fetch possible in T+1.
  - imem_ready low: PEND lasts until the first cycle with imem_ready high; pc=target in the following cycle.
- Flush is asserted only in the cycle redir is high. The wrong-path return that ends PEND is suppressed via fetch_valid, not via flush.
- Reset asserted mid-PEND: the pending target is discarded immediately and the block returns to BOOT.

## Configuration
- FETCH_REDIRECT_STATS_EN defined:
  - redirect_count increments on every redir.
  - pend_count increments on every RUN→PEND transition.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on reset.
- FETCH_REDIRECT_STATS_EN undefined: both ports remain present, are tied to 0, and no counter flops exist.

## Structure
- Shared package pipeline_pkg:
  - XLEN and RESET_PC constants.
  - enum fetch_state_t {BOOT, RUN, PEND}.
- One sub-module, sat_counter (width parameter, inc, clear by reset, saturating). It is instantiated twice, only under FETCH_REDIRECT_STATS_EN.

## Test plan
- Reset deassert, imem_ready=1 for 4 cycles → imem_req 0 then 1; pc sequence 0,0,1,2,3; fetch_valid 0,1,1,1.
- pc=5, ex_valid=1, jump=1, next=0x40, imem_ready=1 → flush_if_id=flush_id_ex=1 that cycle; pc=0x40 next cycle; redirect_count=1.
- pc=5, redir to 0x80 with imem_ready=0 for 3 cycles, then 1 → redirect_pending high 3+1 cycles; fetch_valid=0 on the return cycle; pc=0x80 after; pend_count=1.
- In PEND with pend_target=0x80, second redir next=0xC0 coincident with imem_ready=1 → pc=0xC0; flush asserted.
- stall=1 and redir next=0x10 in the same cycle → pc=0x10 (redirect wins); with stall=1 alone, pc holds for the stall duration.
- pc=32'hFFFF_FFFF, imem_ready=1, no stall → pc=0. Separately, reset mid-PEND → pc=RESET_PC, state BOOT, counters 0.
